// File: rtl/clock_group_reset_sequencer.sv
// Reset sequencer for one clock-group member: synchronized/stretched power-on reset
// plus a software reset with quiesce handshake. Optional macro: RESET_SEQ_QUIESCE_TIMEOUT_EN.
module clock_group_reset_sequencer #(
  parameter int SYNC_STAGES     = 3,
  parameter int STRETCH_CYCLES  = 16,
  parameter int QUIESCE_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_reset_req,
  output logic sw_reset_ack,
  output logic quiesce_req,
  input  logic quiesce_ack,
  output logic auto_out_clock,
  output logic auto_out_reset,
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
  output logic quiesce_timeout,
`endif
  output logic busy
);

  localparam int CNT_MAX = (STRETCH_CYCLES > QUIESCE_TIMEOUT + 1) ? STRETCH_CYCLES : QUIESCE_TIMEOUT + 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] ST_SYNC    = 3'd0;
  localparam logic [2:0] ST_STRETCH = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_QUIESCE = 3'd3;
  localparam logic [2:0] ST_ASSERT  = 3'd4;

  logic [2:0]             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   ack_reg, ack_next;
  logic                   sw_origin_reg, sw_origin_next;
  logic                   rst_out_reg, rst_out_next;
  logic                   timeout_reg, timeout_next;

  // Deassertion synchronizer: preset to ones, shifts in zeros.
  assign sync_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ack_next       = ack_reg;
    sw_origin_next = sw_origin_reg;
    timeout_next   = timeout_reg;
    case (state_reg)
      ST_SYNC: begin
        // Leave on the edge at which the last stage takes its 0.
        if (!sync_next[SYNC_STAGES-1]) begin
          state_next = ST_STRETCH;
          cnt_next   = '0;
        end
      end
      ST_STRETCH: begin
        if (cnt_reg == CNT_W'(STRETCH_CYCLES - 1)) begin
          state_next     = ST_RUN;
          ack_next       = sw_origin_reg;
          sw_origin_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!sw_reset_req) begin
          ack_next = 1'b0;
        end else if (!ack_reg) begin
          state_next   = ST_QUIESCE;
          cnt_next     = '0;
          timeout_next = 1'b0;
        end
      end
      ST_QUIESCE: begin
        if (quiesce_ack) begin
          state_next = ST_ASSERT;
        end
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(QUIESCE_TIMEOUT - 1)) begin
          state_next   = ST_ASSERT;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end
      ST_ASSERT: begin
        state_next     = ST_STRETCH;
        cnt_next       = '0;
        sw_origin_next = 1'b1;
      end
      default: state_next = ST_SYNC;
    endcase
    rst_out_next = (state_next == ST_SYNC) || (state_next == ST_STRETCH) || (state_next == ST_ASSERT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_SYNC;
      cnt_reg       <= '0;
      sync_reg      <= '1;
      ack_reg       <= 1'b0;
      sw_origin_reg <= 1'b0;
      rst_out_reg   <= 1'b1;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sync_reg      <= sync_next;
      ack_reg       <= ack_next;
      sw_origin_reg <= sw_origin_next;
      rst_out_reg   <= rst_out_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign auto_out_clock = clock;
  assign auto_out_reset = rst_out_reg;
  assign sw_reset_ack   = ack_reg;
  assign quiesce_req    = (state_reg == ST_QUIESCE);
  assign busy           = (state_reg != ST_RUN);
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
  assign quiesce_timeout = timeout_reg;
`else
  // Timeout flag only exists as a port when the feature is built in.
  logic unused_timeout;
  assign unused_timeout = timeout_reg;
`endif

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Randomized bench for clock_group_reset_sequencer against a hold-countdown reference model.
// Honors RESET_SEQ_QUIESCE_TIMEOUT_EN when the DUT is built with it.
module tb_clock_group_reset_sequencer;

  localparam int SYNC = 3;
  localparam int STR  = 16;
  localparam int QT   = 10;
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic sw_reset_req;
  logic quiesce_ack;
  logic sw_reset_ack, quiesce_req, auto_out_clock, auto_out_reset, busy;
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
  logic quiesce_timeout;
`endif

  clock_group_reset_sequencer #(
    .SYNC_STAGES(SYNC), .STRETCH_CYCLES(STR), .QUIESCE_TIMEOUT(QT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_reset_req(sw_reset_req),
    .sw_reset_ack(sw_reset_ack),
    .quiesce_req(quiesce_req),
    .quiesce_ack(quiesce_ack),
    .auto_out_clock(auto_out_clock),
    .auto_out_reset(auto_out_reset),
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
    .quiesce_timeout(quiesce_timeout),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: reset output is a countdown of edges still held; quiesce is a wait with an edge count.
  int m_left;
  int m_qcnt;
  bit m_quiesce, m_sw, m_ack, m_to;

  function automatic void model_reset();
    m_left    = SYNC + STR;
    m_quiesce = 1'b0;
    m_sw      = 1'b0;
    m_ack     = 1'b0;
    m_to      = 1'b0;
    m_qcnt    = 0;
  endfunction

  function automatic void model_step();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_sw) begin
        m_ack = 1'b1;
        m_sw  = 1'b0;
        txn++;
        $display("txn %0d: sw reset sequence complete at t=%0t timeout=%0d", txn, $time, m_to);
      end
    end else if (m_quiesce) begin
      m_qcnt++;
      if (quiesce_ack) begin
        m_quiesce = 1'b0;
        m_left    = STR + 1;
        m_sw      = 1'b1;
      end else if (TO_EN && m_qcnt == QT) begin
        m_quiesce = 1'b0;
        m_left    = STR + 1;
        m_sw      = 1'b1;
        m_to      = 1'b1;
      end
    end else begin
      if (!sw_reset_req) m_ack = 1'b0;
      else if (!m_ack) begin
        m_quiesce = 1'b1;
        m_qcnt    = 0;
        m_to      = 1'b0;
      end
    end
  endfunction

  task automatic check_outputs();
    check_eq("clock_pass", auto_out_clock, clock);
    check_eq("out_reset", auto_out_reset, m_left > 0);
    check_eq("busy", busy, (m_left > 0) || m_quiesce);
    check_eq("quiesce_req", quiesce_req, m_quiesce);
    check_eq("sw_ack", sw_reset_ack, m_ack);
`ifdef RESET_SEQ_QUIESCE_TIMEOUT_EN
    check_eq("q_timeout", quiesce_timeout, m_to);
`endif
  endtask

  initial begin
    int rst_hold;
    int seg;
    reset        = 1'b1;
    sw_reset_req = 1'b0;
    quiesce_ack  = 1'b1;
    model_reset();
    rst_hold = 5;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      @(negedge clock);
      check_outputs();
      seg = (cyc / 300) % 4;
      // quiesce_ack profile per segment: tied high, rarely high, coin flip, sparse
      case (seg)
        0:       quiesce_ack = 1'b1;
        1:       quiesce_ack = ($urandom_range(0, 99) < 3);
        2:       quiesce_ack = $urandom_range(0, 1) == 1;
        default: quiesce_ack = ($urandom_range(0, 99) < 20);
      endcase
      if (!sw_reset_req) sw_reset_req = ($urandom_range(0, 7) == 0);
      else if (m_ack)    sw_reset_req = ($urandom_range(0, 1) == 1);
      else if (seg == 2) sw_reset_req = ($urandom_range(0, 1) == 1);
      else               sw_reset_req = ($urandom_range(0, 49) != 0);

      if (reset) begin
        rst_hold--;
        if (rst_hold <= 0) begin
          #2 reset = 1'b0;
        end
      end else if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        $display("txn: async reset at t=%0t", $time);
        check_eq("async_out_reset", auto_out_reset, 1);
        check_eq("async_busy", busy, 1);
        check_eq("async_ack", sw_reset_ack, 0);
        check_eq("async_qreq", quiesce_req, 0);
        rst_hold = $urandom_range(1, 5);
      end
      @(posedge clock);
      model_step();
    end
    @(negedge clock);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
